histogram_accum_ctrl: RTL and testbench
=======================================

Name: histogram_accum_ctrl

Overview:
- Initiator/controller for the dual-address histogram accumulator RAM: drives its read, write and clear-on-read port.
- Accumulates a pixel stream into per-bin counts by read-modify-write with one-deep same-bin forwarding.
- After frame end, sweeps every bin with clear-on-read, streams the counts out and leaves the RAM zeroed for the next frame.
- Sits between the pixel source and the histogram consumer (CDF/equalisation stage).

Parameters:
- DATA_WIDTH, 14, bin counter width.
- DATA_DEPTH, 256, number of bins; ADDRESS_WIDTH = clogb2(DATA_DEPTH-1), 8 by default.

Ports:
- clk  in  1  single clock, all logic on posedge.
- arst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a frame, honoured only in IDLE.
- frame_end  in  1  pulse; last pixel of frame is at or before this cycle.
- pix_data  in  ADDRESS_WIDTH  bin index.
- pix_valid  in  1  pix_data qualifier.
- pix_ready  out  1  high only in ACCUM.
- ram_raddr  out  ADDRESS_WIDTH  RAM read address.
- ram_rvalid  out  1  RAM read strobe.
- ram_clear  out  1  clear-on-read, valid with ram_rvalid.
- ram_rdata  in  DATA_WIDTH  RAM read data, registered in the RAM, 1 cycle after ram_rvalid.
- ram_dvalid  in  1  ram_rdata qualifier.
- ram_waddr  out  ADDRESS_WIDTH  RAM write address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_wvalid  out  1  RAM write strobe.
- hist_addr  out  ADDRESS_WIDTH  bin index of hist_data.
- hist_data  out  DATA_WIDTH  bin count.
- hist_valid  out  1  hist_addr/hist_data qualifier.
- done  out  1  one-cycle pulse after the last bin is output.

Behaviour:
- Reset: state IDLE. All outputs are 0, including pix_ready, done and the RAM strobes. Internal pipeline valid and forward registers clear. Reset mid-frame or mid-readout abandons the operation; this block does not clear RAM contents.
- FSM IDLE -> ACCUM on start.
- ACCUM -> DRAIN on frame_end. A pixel accepted in the same cycle as frame_end is counted.
- DRAIN: one cycle, lets the last write commit, then -> READOUT.
- READOUT: DATA_DEPTH cycles, then -> FLUSH.
- FLUSH: waits for the last hist_valid, pulses done, then -> IDLE.
- start is ignored outside IDLE.
- ACCUM stage 0: on pix_valid & pix_ready, drive ram_raddr=pix_data and ram_rvalid=1 combinationally, ram_clear=0. Register pix_data as p1_addr with p1_valid=1.
- ACCUM stage 1: on the cycle with ram_dvalid and p1_valid:
  - base = fwd_data if fwd_valid and p1_addr==fwd_addr, else ram_rdata.
  - ram_wdata = base+1, ram_waddr = p1_addr, ram_wvalid = 1.
  - Register fwd_addr = p1_addr, fwd_data = base+1, fwd_valid = 1.
- Hazard: the read for pixel k+1 is sampled on the same edge that commits pixel k's write, so it returns a stale value. Forwarding covers exactly this one-deep case; no stalls are required and throughput is 1 pixel/cycle.
- fwd_valid clears whenever no write occurs that cycle.
- Arithmetic: increment at DATA_WIDTH width. Wrap or saturate per the optional feature.
- READOUT: in cycle n (n=0..DATA_DEPTH-1), drive ram_raddr=n, ram_rvalid=1, ram_clear=1, ram_wvalid=0.
- Readout output: on ram_dvalid, register hist_data=ram_rdata, hist_addr=n, hist_valid=1. hist_valid for bin n is asserted 2 cycles after its read is issued. There is no backpressure.
- done is asserted the cycle after hist_valid for bin DATA_DEPTH-1.
- pix_valid outside ACCUM is dropped (pix_ready=0).
- Frame with zero pixels: readout still runs and outputs all zeros.

Optional Feature:
- Macro HIST_SATURATE_EN.
- Defined: the increment saturates at 2^DATA_WIDTH-1; further hits leave the bin at max.
- Undefined: the increment wraps modulo 2^DATA_WIDTH.

Test Plan:
- Reset: assert arst mid-ACCUM -> all outputs 0 immediately; state IDLE; start accepted after release.
- Single pixel: start, pix 5, frame_end -> readout hist_data=1 at hist_addr 5, 0 elsewhere; 256 hist_valid beats, then one done pulse.
- Back-to-back same bin: pix 7,7,7,7 on consecutive cycles -> bin 7 = 4, proving forwarding.
- Interleaved 3,4,3,4,3 -> bin3=3, bin4=2; gapped 9,-,9 -> bin9=2.
- Clear-on-read: frame 1 with 10 pixels in bin 200, then empty frame 2 -> frame 2 readout is all zeros.
- DATA_WIDTH=4, 17 pixels in bin 1:
  - With HIST_SATURATE_EN -> 15.
  - Without -> 1.

Source files
------------

// File: rtl/histogram_accum_ctrl_if.sv
// rtl/histogram_accum_ctrl_if.sv - histogram accumulator RAM port bundle
// Ports:
//   ram_raddr/ram_rvalid/ram_clear : read request, clear-on-read (master -> RAM)
//   ram_rdata/ram_dvalid           : registered read data, one cycle after request (RAM -> master)
//   ram_waddr/ram_wdata/ram_wvalid : write request (master -> RAM)
interface histogram_accum_ctrl_if #(
  parameter int DATA_WIDTH    = 14,
  parameter int ADDRESS_WIDTH = 8
);
  logic [ADDRESS_WIDTH-1:0] ram_raddr;
  logic                     ram_rvalid;
  logic                     ram_clear;
  logic [DATA_WIDTH-1:0]    ram_rdata;
  logic                     ram_dvalid;
  logic [ADDRESS_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic                     ram_wvalid;

  modport master (
    output ram_raddr, ram_rvalid, ram_clear,
    input  ram_rdata, ram_dvalid,
    output ram_waddr, ram_wdata, ram_wvalid
  );

  modport slave (
    input  ram_raddr, ram_rvalid, ram_clear,
    output ram_rdata, ram_dvalid,
    input  ram_waddr, ram_wdata, ram_wvalid
  );
endinterface

// File: rtl/histogram_accum_ctrl.sv
// rtl/histogram_accum_ctrl.sv - histogram accumulate / clear-on-read readout controller
// Optional feature macro: HIST_SATURATE_EN (bin counts saturate instead of wrapping).
// Ports:
//   clk, arst                      : clock, asynchronous active-high reset
//   start, frame_end               : frame control pulses
//   pix_data/pix_valid/pix_ready   : pixel bin stream in (ready only while accumulating)
//   ram                            : master side of the accumulator RAM port bundle
//   hist_addr/hist_data/hist_valid : per-bin count stream out, no backpressure
//   done                           : one-cycle pulse after the last bin is output
module histogram_accum_ctrl #(
  parameter int DATA_WIDTH    = 14,
  parameter int DATA_DEPTH    = 256,
  // Bits needed to index bin DATA_DEPTH-1.
  parameter int ADDRESS_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     start,
  input  logic                     frame_end,
  input  logic [ADDRESS_WIDTH-1:0] pix_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  histogram_accum_ctrl_if.master   ram,
  output logic [ADDRESS_WIDTH-1:0] hist_addr,
  output logic [DATA_WIDTH-1:0]    hist_data,
  output logic                     hist_valid,
  output logic                     done
);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    READOUT,
    FLUSH
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_BIN = ADDRESS_WIDTH'(DATA_DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0]    CNT_MAX  = '1;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] rd_cnt;

  // Accumulate pipeline: stage 1 holds the bin whose read data arrives this cycle.
  logic                     p1_valid;
  logic [ADDRESS_WIDTH-1:0] p1_addr;

  // Last written bin/value; covers the read that was sampled alongside that write.
  logic                     fwd_valid;
  logic [ADDRESS_WIDTH-1:0] fwd_addr;
  logic [DATA_WIDTH-1:0]    fwd_data;

  // Readout pipeline: bin index matching the read data arriving this cycle.
  logic                     ro_valid;
  logic [ADDRESS_WIDTH-1:0] ro_addr;

  logic                     pix_fire;
  logic                     upd_fire;
  logic [DATA_WIDTH-1:0]    base;
  logic [DATA_WIDTH-1:0]    incr;

  assign pix_ready = (state == ACCUM);
  assign pix_fire  = pix_valid & pix_ready;
  assign upd_fire  = p1_valid & ram.ram_dvalid;
  assign base      = (fwd_valid && (fwd_addr == p1_addr)) ? fwd_data : ram.ram_rdata;

`ifdef HIST_SATURATE_EN
  assign incr = (base == CNT_MAX) ? base : base + DATA_WIDTH'(1);
`else
  assign incr = base + DATA_WIDTH'(1);
`endif

  // Read port: the readout sweep owns it in READOUT, pixels own it in ACCUM.
  always_comb begin
    ram.ram_raddr  = '0;
    ram.ram_rvalid = 1'b0;
    ram.ram_clear  = 1'b0;
    if (state == READOUT) begin
      ram.ram_raddr  = rd_cnt;
      ram.ram_rvalid = 1'b1;
      ram.ram_clear  = 1'b1;
    end else if (pix_fire) begin
      ram.ram_raddr  = pix_data;
      ram.ram_rvalid = 1'b1;
    end
  end

  // Write port is gated so it reads as all-zero whenever no update is in flight.
  assign ram.ram_wvalid = upd_fire;
  assign ram.ram_waddr  = upd_fire ? p1_addr : '0;
  assign ram.ram_wdata  = upd_fire ? incr : '0;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      p1_valid   <= 1'b0;
      p1_addr    <= '0;
      fwd_valid  <= 1'b0;
      fwd_addr   <= '0;
      fwd_data   <= '0;
      ro_valid   <= 1'b0;
      ro_addr    <= '0;
      hist_valid <= 1'b0;
      hist_addr  <= '0;
      hist_data  <= '0;
      done       <= 1'b0;
    end else begin
      p1_valid <= pix_fire;
      if (pix_fire) begin
        p1_addr <= pix_data;
      end

      fwd_valid <= upd_fire;
      if (upd_fire) begin
        fwd_addr <= p1_addr;
        fwd_data <= incr;
      end

      ro_valid   <= (state == READOUT);
      ro_addr    <= rd_cnt;
      hist_valid <= ro_valid & ram.ram_dvalid;
      if (ro_valid && ram.ram_dvalid) begin
        hist_addr <= ro_addr;
        hist_data <= ram.ram_rdata;
      end

      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (frame_end) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The final pixel's write is on the port this cycle.
          state  <= READOUT;
          rd_cnt <= '0;
        end
        READOUT: begin
          rd_cnt <= rd_cnt + ADDRESS_WIDTH'(1);
          if (rd_cnt == LAST_BIN) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (hist_valid && (hist_addr == LAST_BIN)) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_accum_ctrl.sv
// tb/tb_histogram_accum_ctrl.sv - self-checking bench for histogram_accum_ctrl
module tb_histogram_accum_ctrl;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic wipe = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main instance: 14-bit counts, 256 bins ----------------
  logic       start = 1'b0, frame_end = 1'b0, pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_ready, hist_valid, done;
  logic [7:0] hist_addr;
  logic [13:0] hist_data;

  histogram_accum_ctrl_if #(.DATA_WIDTH(14), .ADDRESS_WIDTH(8)) ram_bus ();

  histogram_accum_ctrl #(.DATA_WIDTH(14), .DATA_DEPTH(256)) dut (
    .clk(clk), .arst(arst), .start(start), .frame_end(frame_end),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ram(ram_bus), .hist_addr(hist_addr), .hist_data(hist_data),
    .hist_valid(hist_valid), .done(done)
  );

  // Behavioural RAM: registered read, read-before-write, clear-on-read.
  logic [13:0] mem [256];
  always @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      ram_bus.ram_dvalid <= 1'b0;
      ram_bus.ram_rdata  <= '0;
    end else begin
      ram_bus.ram_dvalid <= ram_bus.ram_rvalid;
      if (ram_bus.ram_rvalid) begin
        ram_bus.ram_rdata <= mem[ram_bus.ram_raddr];
        if (ram_bus.ram_clear) mem[ram_bus.ram_raddr] <= '0;
      end
      if (ram_bus.ram_wvalid) mem[ram_bus.ram_waddr] <= ram_bus.ram_wdata;
    end
  end

  // ---------------- small instance: 4-bit counts, 16 bins ----------------
  logic       s_start = 1'b0, s_frame_end = 1'b0, s_pix_valid = 1'b0;
  logic [3:0] s_pix_data = '0;
  logic       s_pix_ready, s_hist_valid, s_done;
  logic [3:0] s_hist_addr;
  logic [3:0] s_hist_data;

  histogram_accum_ctrl_if #(.DATA_WIDTH(4), .ADDRESS_WIDTH(4)) s_bus ();

  histogram_accum_ctrl #(.DATA_WIDTH(4), .DATA_DEPTH(16)) s_dut (
    .clk(clk), .arst(arst), .start(s_start), .frame_end(s_frame_end),
    .pix_data(s_pix_data), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
    .ram(s_bus), .hist_addr(s_hist_addr), .hist_data(s_hist_data),
    .hist_valid(s_hist_valid), .done(s_done)
  );

  logic [3:0] smem [16];
  always @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < 16; i++) smem[i] <= '0;
      s_bus.ram_dvalid <= 1'b0;
      s_bus.ram_rdata  <= '0;
    end else begin
      s_bus.ram_dvalid <= s_bus.ram_rvalid;
      if (s_bus.ram_rvalid) begin
        s_bus.ram_rdata <= smem[s_bus.ram_raddr];
        if (s_bus.ram_clear) smem[s_bus.ram_raddr] <= '0;
      end
      if (s_bus.ram_wvalid) smem[s_bus.ram_waddr] <= s_bus.ram_wdata;
    end
  end

  // ---------------- model: expected histogram per frame ----------------
  int exp_cnt [256];
  int got [256];
  int exp_idx = 0;
  int done_count = 0;
  bit prev_last = 1'b0;
  bit prev_done = 1'b0;
  int issue_q [$];
  int stim [$];

  always @(negedge clk) begin
    if (!arst && !wipe) begin
      if (ram_bus.ram_rvalid && ram_bus.ram_clear) issue_q.push_back(cyc);
      chk("no_write_during_readout", ram_bus.ram_clear && ram_bus.ram_wvalid, 0);
      if (hist_valid) begin
        chk("hist_addr", hist_addr, exp_idx);
        chk("hist_data", hist_data, exp_cnt[exp_idx & 255] % 16384);
        got[hist_addr] = hist_data;
        if (issue_q.size() == 0) chk("hist_without_read", 1, 0);
        else chk("hist_latency", cyc - issue_q.pop_front(), 2);
        exp_idx++;
      end
      if (done) begin
        chk("done_after_last_bin", prev_last, 1);
        chk("bins_per_frame", exp_idx, 256);
        chk("done_single_cycle", prev_done, 0);
        exp_idx = 0;
        done_count++;
      end else if (prev_last) begin
        chk("done_missing", 0, 1);
      end
      prev_last = hist_valid && (hist_addr == 8'd255);
      prev_done = done;
    end
  end

  int s_got [16];
  int s_hv_cnt = 0;
  int s_done_cnt = 0;
  always @(negedge clk) begin
    if (!arst && !wipe) begin
      if (s_hist_valid) begin
        s_got[s_hist_addr] = s_hist_data;
        s_hv_cnt++;
      end
      if (s_done) s_done_cnt++;
    end
  end

  // Runs one frame from stim (-1 = idle cycle); frame_end rides on the last entry.
  task automatic run_frame(input string tag);
    int d0;
    d0 = done_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_pix_ready_in_accum"}, pix_ready, 1);
    if (stim.size() == 0) begin
      frame_end = 1'b1;
      tick();
    end
    for (int i = 0; i < stim.size(); i++) begin
      if (stim[i] >= 0) begin
        pix_valid = 1'b1;
        pix_data  = 8'(stim[i]);
        exp_cnt[stim[i]]++;
      end else begin
        pix_valid = 1'b0;
      end
      frame_end = (i == stim.size() - 1);
      tick();
    end
    pix_valid = 1'b0;
    frame_end = 1'b0;
    for (int k = 0; k < 400 && done_count == d0; k++) tick();
    chk({tag, "_done_seen"}, done_count, d0 + 1);
    tick();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) exp_cnt[i] = 0;
    stim.delete();
  endtask

  int sat_exp;
  int nz;

  initial begin
    clear_model();
    repeat (3) tick();
    // Reset values.
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_rvalid", ram_bus.ram_rvalid, 0);
    chk("rst_wvalid", ram_bus.ram_wvalid, 0);
    chk("rst_hist_valid", hist_valid, 0);
    chk("rst_done", done, 0);
    arst = 1'b0;
    wipe = 1'b0;
    tick();

    // Pixels offered in IDLE are dropped.
    pix_valid = 1'b1;
    pix_data  = 8'd5;
    tick();
    chk("idle_pix_ready", pix_ready, 0);
    chk("idle_rvalid", ram_bus.ram_rvalid, 0);
    pix_valid = 1'b0;
    tick();

    // Reset asserted mid-ACCUM with a write in flight.
    start = 1'b1;
    tick();
    start = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'd3;
    tick();
    pix_data = 8'd4;
    chk("pre_rst_wvalid", ram_bus.ram_wvalid, 1);
    #2 arst = 1'b1;
    #1;
    chk("arst_pix_ready", pix_ready, 0);
    chk("arst_rvalid", ram_bus.ram_rvalid, 0);
    chk("arst_wvalid", ram_bus.ram_wvalid, 0);
    chk("arst_waddr", ram_bus.ram_waddr, 0);
    chk("arst_wdata", ram_bus.ram_wdata, 0);
    chk("arst_hist_valid", hist_valid, 0);
    pix_valid = 1'b0;
    tick();
    arst = 1'b0;
    wipe = 1'b1;
    tick();
    wipe = 1'b0;
    tick();
    chk("post_rst_idle", pix_ready, 0);

    // Frame A: single pixel in bin 5.
    clear_model();
    stim = '{5};
    run_frame("single");
    chk("model_single_bin5", exp_cnt[5], 1);
    chk("single_bin5", got[5], 1);
    chk("single_bin6", got[6], 0);

    // Frame B: back-to-back, interleaved and gapped hits.
    clear_model();
    stim = '{7, 7, 7, 7, 3, 4, 3, 4, 3, -1, 9, -1, 9};
    run_frame("mixed");
    chk("fwd_bin7", got[7], 4);
    chk("interleave_bin3", got[3], 3);
    chk("interleave_bin4", got[4], 2);
    chk("gapped_bin9", got[9], 2);
    chk("mixed_bin8", got[8], 0);

    // Frame C then empty frame D: clear-on-read leaves the RAM zeroed.
    clear_model();
    for (int i = 0; i < 10; i++) stim.push_back(200);
    run_frame("bin200");
    chk("bin200_count", got[200], 10);
    clear_model();
    run_frame("empty");
    chk("empty_bin200", got[200], 0);
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != 0) nz++;
    chk("ram_zeroed", nz, 0);
    chk("frames_done", done_count, 4);

    // Narrow counter: 17 hits in bin 1.
`ifdef HIST_SATURATE_EN
    sat_exp = 15;
`else
    sat_exp = 1;
`endif
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("narrow_pix_ready", s_pix_ready, 1);
    for (int i = 0; i < 17; i++) begin
      s_pix_valid = 1'b1;
      s_pix_data  = 4'd1;
      s_frame_end = (i == 16);
      tick();
    end
    s_pix_valid = 1'b0;
    s_frame_end = 1'b0;
    for (int k = 0; k < 100 && s_done_cnt == 0; k++) tick();
    tick();
    chk("narrow_done", s_done_cnt, 1);
    chk("narrow_beats", s_hv_cnt, 16);
    chk("narrow_bin1", s_got[1], sat_exp);
    chk("narrow_bin0", s_got[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
